square_raster: RTL and testbench

- Display-side consumer of the square-coordinate bus produced by the animation block.
- Generates 640x480 VGA timing from a pixel strobe and issues the per-frame animation strobe back to the animator.
- Captures the square edges once per frame into shadow registers so each frame is drawn tear-free.
- Outputs sync signals, pixel position, and a per-pixel "inside square" draw flag to the colour mux.

---
 rtl/square_raster.sv | 116 +++++++++++
 tb/tb_square_raster.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/square_raster.sv
// VGA 640x480 raster timing with a once-per-frame latched square overlay.
// Define SQUARE_OUTLINE_EN to draw only a 2-pixel border instead of a solid fill.
module square_raster #(
  parameter logic [9:0] HS_STA = 10'd16,
  parameter logic [9:0] HS_END = 10'd112,
  parameter logic [9:0] HA_STA = 10'd160,
  parameter logic [9:0] VS_STA = 10'd490,
  parameter logic [9:0] VS_END = 10'd492,
  parameter logic [9:0] VA_END = 10'd480,
  parameter logic [9:0] LINE   = 10'd800,
  parameter logic [9:0] SCREEN = 10'd525
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_pix_stb,
  input  logic [11:0] i_x1,
  input  logic [11:0] i_x2,
  input  logic [11:0] i_y1,
  input  logic [11:0] i_y2,
  output logic        o_hs,
  output logic        o_vs,
  output logic        o_blanking,
  output logic        o_active,
  output logic        o_animate,
  output logic        o_screenend,
  output logic [9:0]  o_x,
  output logic [8:0]  o_y,
  output logic        o_draw
);

  localparam logic [9:0] Y_LAST = VA_END - 10'd1;

  logic [9:0]  h_cnt;
  logic [9:0]  v_cnt;
  logic [11:0] sx1, sx2, sy1, sy2;
  logic        line_end;
  logic        ani_end;
  logic        frame_end;

  assign line_end  = i_pix_stb && (h_cnt == LINE - 10'd1);
  assign ani_end   = line_end && (v_cnt == VA_END - 10'd1);
  assign frame_end = line_end && (v_cnt == SCREEN - 10'd1);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (i_pix_stb) begin
      if (h_cnt == LINE - 10'd1) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == SCREEN - 10'd1) ? 10'd0 : v_cnt + 10'd1;
      end else begin
        h_cnt <= h_cnt + 10'd1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_animate   <= 1'b0;
      o_screenend <= 1'b0;
    end else begin
      o_animate   <= ani_end;
      o_screenend <= frame_end;
    end
  end

  // Square edges are sampled only on the frame wrap so a frame never tears.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sx1 <= '0;
      sx2 <= '0;
      sy1 <= '0;
      sy2 <= '0;
    end else if (frame_end) begin
      sx1 <= i_x1;
      sx2 <= i_x2;
      sy1 <= i_y1;
      sy2 <= i_y2;
    end
  end

  assign o_hs       = !((h_cnt >= HS_STA) && (h_cnt < HS_END));
  assign o_vs       = !((v_cnt >= VS_STA) && (v_cnt < VS_END));
  assign o_active   = (h_cnt >= HA_STA) && (v_cnt < VA_END);
  assign o_blanking = !o_active;
  assign o_x        = (h_cnt < HA_STA) ? 10'd0 : h_cnt - HA_STA;
  assign o_y        = (v_cnt >= VA_END) ? Y_LAST[8:0] : v_cnt[8:0];

  logic [11:0] px;
  logic [11:0] py;
  logic        in_box;

  assign px     = {2'b00, o_x};
  assign py     = {3'b000, o_y};
  assign in_box = o_active && (sx1 <= px) && (px < sx2) && (sy1 <= py) && (py < sy2);

`ifdef SQUARE_OUTLINE_EN
  // 13-bit inner bounds keep the +2/-2 shrink from wrapping near the 12-bit limits.
  logic [12:0] ix1, ix2, iy1, iy2;
  logic        narrow;
  logic        interior;

  assign ix1      = {1'b0, sx1} + 13'd2;
  assign ix2      = {1'b0, sx2} - 13'd2;
  assign iy1      = {1'b0, sy1} + 13'd2;
  assign iy2      = {1'b0, sy2} - 13'd2;
  assign narrow   = ((sx2 - sx1) <= 12'd4) || ((sy2 - sy1) <= 12'd4);
  assign interior = (ix1 <= {1'b0, px}) && ({1'b0, px} < ix2) &&
                    (iy1 <= {1'b0, py}) && ({1'b0, py} < iy2);
  assign o_draw   = in_box && (narrow || !interior);
`else
  assign o_draw = in_box;
`endif

endmodule

// File: tb/tb_square_raster.sv
// Directed bench for square_raster: a shrunken 40x30 geometry for frame-level
// checks plus a default-geometry instance for the real horizontal decode points.
module tb_square_raster;

  localparam int T_HS_STA = 2;
  localparam int T_HS_END = 6;
  localparam int T_HA_STA = 10;
  localparam int T_VS_STA = 22;
  localparam int T_VS_END = 24;
  localparam int T_VA_END = 20;
  localparam int T_LINE   = 40;
  localparam int T_SCREEN = 30;
  localparam int FRAME    = T_LINE * T_SCREEN;

`ifdef SQUARE_OUTLINE_EN
  localparam int EXP_SQ = 56;
`else
  localparam int EXP_SQ = 80;
`endif
  localparam int EXP_NARROW = 32;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_pix_stb;
  logic        stb_full;
  logic [11:0] i_x1, i_x2, i_y1, i_y2;
  logic        o_hs, o_vs, o_blanking, o_active, o_animate, o_screenend, o_draw;
  logic [9:0]  o_x;
  logic [8:0]  o_y;
  logic        f_hs, f_vs, f_blanking, f_active, f_animate, f_screenend, f_draw;
  logic [9:0]  f_x;
  logic [8:0]  f_y;

  int compared   = 0;
  int mismatched = 0;

  int mh = 0, mv = 0;
  int draws, hs_low, vs_low, ani_cnt, end_cnt, bad_pos, bad_width, right_draws;
  int first_x, first_y;
  bit seen_draw, prev_ani, prev_end;

  always #5 i_clk = ~i_clk;

  square_raster #(
    .HS_STA(10'd2), .HS_END(10'd6), .HA_STA(10'd10), .VS_STA(10'd22),
    .VS_END(10'd24), .VA_END(10'd20), .LINE(10'd40), .SCREEN(10'd30)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_pix_stb(i_pix_stb),
    .i_x1(i_x1), .i_x2(i_x2), .i_y1(i_y1), .i_y2(i_y2),
    .o_hs(o_hs), .o_vs(o_vs), .o_blanking(o_blanking), .o_active(o_active),
    .o_animate(o_animate), .o_screenend(o_screenend),
    .o_x(o_x), .o_y(o_y), .o_draw(o_draw)
  );

  square_raster dut_full (
    .i_clk(i_clk), .i_rst(i_rst), .i_pix_stb(stb_full),
    .i_x1(i_x1), .i_x2(i_x2), .i_y1(i_y1), .i_y2(i_y2),
    .o_hs(f_hs), .o_vs(f_vs), .o_blanking(f_blanking), .o_active(f_active),
    .o_animate(f_animate), .o_screenend(f_screenend),
    .o_x(f_x), .o_y(f_y), .o_draw(f_draw)
  );

  typedef struct {
    int   h;
    int   v;
    logic hs;
    logic vs;
    logic act;
    int   x;
    int   y;
  } vec_t;

  typedef struct {
    int   h;
    logic hs;
    logic act;
    int   x;
  } fvec_t;

  vec_t  vecs[13];
  fvec_t fvecs[9];

  task automatic checkOutput(input string name, input int actual, input int expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic clearCounters();
    draws = 0; hs_low = 0; vs_low = 0; ani_cnt = 0; end_cnt = 0;
    bad_pos = 0; bad_width = 0; right_draws = 0;
    first_x = -1; first_y = -1; seen_draw = 0;
  endtask

  // One clock of stimulus; the model position advances independently of the DUT.
  task automatic applyStimulus(input logic stb, input logic rst);
    i_pix_stb = stb;
    i_rst     = rst;
    if (stb && !rst) begin
      if (o_draw) begin
        draws++;
        if (!seen_draw) begin
          seen_draw = 1;
          first_x   = int'(o_x);
          first_y   = int'(o_y);
        end
        if (o_x == 10'd15) right_draws++;
      end
      if (!o_hs) hs_low++;
      if (!o_vs) vs_low++;
    end
    @(posedge i_clk);
    #1;
    if (rst) begin
      mh = 0;
      mv = 0;
    end else if (stb) begin
      if (mh == T_LINE - 1) begin
        mh = 0;
        mv = (mv == T_SCREEN - 1) ? 0 : mv + 1;
      end else begin
        mh = mh + 1;
      end
    end
    if (o_animate) begin
      ani_cnt++;
      if (!(mh == 0 && mv == T_VA_END)) bad_pos++;
      if (prev_ani) bad_width++;
    end
    if (o_screenend) begin
      end_cnt++;
      if (!(mh == 0 && mv == 0)) bad_pos++;
      if (prev_end) bad_width++;
    end
    prev_ani = o_animate;
    prev_end = o_screenend;
  endtask

  task automatic strobePixel();
    applyStimulus(1'b1, 1'b0);
    repeat (3) applyStimulus(1'b0, 1'b0);
  endtask

  task automatic runStrobes(input int n);
    for (int i = 0; i < n; i++) strobePixel();
  endtask

  task automatic advanceTo(input int h, input int v);
    int budget = 0;
    while (!(mh == h && mv == v) && budget < 2 * FRAME) begin
      strobePixel();
      budget++;
    end
    if (!(mh == h && mv == v)) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL reach_%0d_%0d: got h=%0d v=%0d", h, v, mh, mv);
    end
  endtask

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: simulation time limit expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vecs[0]  = '{0,  0,  1'b1, 1'b1, 1'b0, 0,  0};
    vecs[1]  = '{2,  0,  1'b0, 1'b1, 1'b0, 0,  0};
    vecs[2]  = '{5,  0,  1'b0, 1'b1, 1'b0, 0,  0};
    vecs[3]  = '{6,  0,  1'b1, 1'b1, 1'b0, 0,  0};
    vecs[4]  = '{9,  3,  1'b1, 1'b1, 1'b0, 0,  3};
    vecs[5]  = '{10, 3,  1'b1, 1'b1, 1'b1, 0,  3};
    vecs[6]  = '{39, 19, 1'b1, 1'b1, 1'b1, 29, 19};
    vecs[7]  = '{0,  20, 1'b1, 1'b1, 1'b0, 0,  19};
    vecs[8]  = '{10, 20, 1'b1, 1'b1, 1'b0, 0,  19};
    vecs[9]  = '{0,  22, 1'b1, 1'b0, 1'b0, 0,  19};
    vecs[10] = '{39, 23, 1'b1, 1'b0, 1'b0, 29, 19};
    vecs[11] = '{0,  24, 1'b1, 1'b1, 1'b0, 0,  19};
    vecs[12] = '{39, 29, 1'b1, 1'b1, 1'b0, 29, 19};

    fvecs[0] = '{0,   1'b1, 1'b0, 0};
    fvecs[1] = '{15,  1'b1, 1'b0, 0};
    fvecs[2] = '{16,  1'b0, 1'b0, 0};
    fvecs[3] = '{111, 1'b0, 1'b0, 0};
    fvecs[4] = '{112, 1'b1, 1'b0, 0};
    fvecs[5] = '{159, 1'b1, 1'b0, 0};
    fvecs[6] = '{160, 1'b1, 1'b1, 0};
    fvecs[7] = '{161, 1'b1, 1'b1, 1};
    fvecs[8] = '{799, 1'b1, 1'b1, 639};

    i_rst = 1'b1; i_pix_stb = 1'b0; stb_full = 1'b0;
    i_x1 = '0; i_x2 = '0; i_y1 = '0; i_y2 = '0;
    prev_ani = 0; prev_end = 0;
    clearCounters();

    // Reset held with the strobe high must still leave everything at the origin.
    repeat (3) applyStimulus(1'b1, 1'b1);
    checkOutput("rst_hs", int'(o_hs), 1);
    checkOutput("rst_vs", int'(o_vs), 1);
    checkOutput("rst_active", int'(o_active), 0);
    checkOutput("rst_blanking", int'(o_blanking), 1);
    checkOutput("rst_draw", int'(o_draw), 0);
    checkOutput("rst_animate", int'(o_animate), 0);
    checkOutput("rst_screenend", int'(o_screenend), 0);
    checkOutput("rst_x", int'(o_x), 0);
    checkOutput("rst_y", int'(o_y), 0);
    checkOutput("rst_full_hs", int'(f_hs), 1);
    checkOutput("rst_full_vs", int'(f_vs), 1);

    i_rst = 1'b0;
    i_pix_stb = 1'b0;
    stb_full = 1'b1;
    begin
      int kfull = 0;
      for (int i = 0; i < 9; i++) begin
        while (kfull < fvecs[i].h) begin
          @(posedge i_clk);
          #1;
          kfull++;
        end
        checkOutput($sformatf("full_hs_h%0d", fvecs[i].h), int'(f_hs), int'(fvecs[i].hs));
        checkOutput($sformatf("full_act_h%0d", fvecs[i].h), int'(f_active), int'(fvecs[i].act));
        checkOutput($sformatf("full_x_h%0d", fvecs[i].h), int'(f_x), fvecs[i].x);
        checkOutput($sformatf("full_y_h%0d", fvecs[i].h), int'(f_y), 0);
      end
    end
    stb_full = 1'b0;
    repeat (5) @(posedge i_clk);
    #1;
    checkOutput("full_hold_x", int'(f_x), 639);
    checkOutput("hold_small_x", int'(o_x), 0);

    for (int i = 0; i < 13; i++) begin
      advanceTo(vecs[i].h, vecs[i].v);
      checkOutput($sformatf("hs_%0d_%0d", vecs[i].h, vecs[i].v), int'(o_hs), int'(vecs[i].hs));
      checkOutput($sformatf("vs_%0d_%0d", vecs[i].h, vecs[i].v), int'(o_vs), int'(vecs[i].vs));
      checkOutput($sformatf("act_%0d_%0d", vecs[i].h, vecs[i].v), int'(o_active), int'(vecs[i].act));
      checkOutput($sformatf("blank_%0d_%0d", vecs[i].h, vecs[i].v), int'(o_blanking), int'(!vecs[i].act));
      checkOutput($sformatf("x_%0d_%0d", vecs[i].h, vecs[i].v), int'(o_x), vecs[i].x);
      checkOutput($sformatf("y_%0d_%0d", vecs[i].h, vecs[i].v), int'(o_y), vecs[i].y);
    end

    // Three full frames with empty shadows: pulse counts, sync widths, no drawing.
    clearCounters();
    runStrobes(3 * FRAME);
    checkOutput("pulse_animate_cnt", ani_cnt, 3);
    checkOutput("pulse_screenend_cnt", end_cnt, 3);
    checkOutput("pulse_position", bad_pos, 0);
    checkOutput("pulse_width", bad_width, 0);
    checkOutput("hs_low_strobes", hs_low, (T_HS_END - T_HS_STA) * T_SCREEN * 3);
    checkOutput("vs_low_strobes", vs_low, (T_VS_END - T_VS_STA) * T_LINE * 3);
    checkOutput("empty_shadow_draws", draws, 0);

    // Square x 5..14, y 4..11 latched on the next wrap.
    i_x1 = 12'd5; i_x2 = 12'd15; i_y1 = 12'd4; i_y2 = 12'd12;
    strobePixel();
    clearCounters();
    runStrobes(FRAME);
    checkOutput("sq_draws", draws, EXP_SQ);
    checkOutput("sq_first_x", first_x, 5);
    checkOutput("sq_first_y", first_y, 4);
    checkOutput("sq_right_edge", right_draws, 0);

    // Edges change mid-frame: this frame keeps the old square.
    clearCounters();
    advanceTo(0, 5);
    i_x1 = 12'd0; i_x2 = 12'd4;
    advanceTo(0, 0);
    checkOutput("midchg_old_draws", draws, EXP_SQ);
    checkOutput("midchg_old_first_x", first_x, 5);

    clearCounters();
    runStrobes(FRAME - 1);
    checkOutput("midchg_new_draws", draws, EXP_NARROW);
    checkOutput("midchg_new_first_x", first_x, 0);
    checkOutput("midchg_new_first_y", first_y, 4);

    // Wrapped left edge (x1 > x2) must draw nothing.
    i_x1 = 12'd4090; i_x2 = 12'd70;
    strobePixel();
    clearCounters();
    advanceTo(T_LINE - 1, T_VA_END - 1);
    checkOutput("wrapped_draws", draws, 0);

    // Reset exactly when the animate pulse would have been launched.
    applyStimulus(1'b1, 1'b1);
    checkOutput("midrst_animate", int'(o_animate), 0);
    checkOutput("midrst_screenend", int'(o_screenend), 0);
    checkOutput("midrst_x", int'(o_x), 0);
    checkOutput("midrst_y", int'(o_y), 0);
    checkOutput("midrst_active", int'(o_active), 0);
    checkOutput("midrst_hs", int'(o_hs), 1);
    applyStimulus(1'b0, 1'b0);
    checkOutput("midrst_animate_next", int'(o_animate), 0);

    clearCounters();
    runStrobes(12);
    checkOutput("postrst_x", int'(o_x), 2);
    checkOutput("postrst_active", int'(o_active), 1);
    runStrobes(FRAME - 12);
    checkOutput("postrst_draws", draws, 0);
    checkOutput("postrst_animate_cnt", ani_cnt, 1);
    checkOutput("postrst_screenend_cnt", end_cnt, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
